// File: rtl/wb_cmd_master.sv
// wb_cmd_master -- Wishbone classic-cycle master fed by a queued command stream.
//
// Commands (read/write, address, data) are buffered in a CMD_DEPTH-entry FIFO and
// executed one bus cycle at a time. Each finished cycle returns a response
// (read data or write-data echo, error flag) through a valid/ready channel.
// Responses come back strictly in command order.
//
// Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN
//   When defined, a cycle that sees neither ack_i nor err_i for TIMEOUT_CYCLES
//   clocks is aborted and reported as an error with zero data. When undefined
//   no timeout counter exists and a cycle waits for the slave indefinitely.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o command handshake; cmd_ready_o = FIFO not full
//   cmd_we_i/addr_i/data_i  command payload (data ignored for reads)
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_we_o/data_o/err_o   response payload
//   busy_o                  FIFO non-empty or a transaction in flight
//   cyc_o/stb_o/we_o/adr_o/dat_o, dat_i/ack_i/err_i   Wishbone master side
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  // Reject parameter values the FIFO pointers and timeout counter cannot support.
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("wb_cmd_master: CMD_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  // Command FIFO storage and pointers; the extra pointer MSB tells full from empty.
  logic [CMD_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W:0]   wr_ptr_r, rd_ptr_r;
  logic             empty_s, full_s, push_s, pop_s;
  logic [CMD_W-1:0] head_s;

  state_t                state_r, state_nxt_s;
  logic                  cyc_r, cyc_nxt_s;
  logic                  we_r, we_nxt_s;
  logic [ADDR_WIDTH-1:0] adr_r, adr_nxt_s;
  logic [DATA_WIDTH-1:0] dat_r, dat_nxt_s;
  logic                  rsp_valid_r, rsp_valid_nxt_s;
  logic                  rsp_we_r, rsp_we_nxt_s;
  logic [DATA_WIDTH-1:0] rsp_data_r, rsp_data_nxt_s;
  logic                  rsp_err_r, rsp_err_nxt_s;
  logic                  timeout_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign push_s  = cmd_valid_i && !full_s;
  assign head_s  = fifo_mem[rd_ptr_r[PTR_W-1:0]];

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_r;

  // Cycles spent in REQ; held at zero elsewhere so it starts from 0 on every REQ entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt_r <= '0;
    end else if (state_r == ST_REQ) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == ST_REQ) && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // FIFO write port; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem[wr_ptr_r[PTR_W-1:0]] <= {cmd_we_i, cmd_addr_i, cmd_data_i};
    end
  end

  // FIFO pointers; a simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Next-state and next-output logic for the bus/response sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    cyc_nxt_s       = cyc_r;
    we_nxt_s        = we_r;
    adr_nxt_s       = adr_r;
    dat_nxt_s       = dat_r;
    rsp_valid_nxt_s = rsp_valid_r;
    rsp_we_nxt_s    = rsp_we_r;
    rsp_data_nxt_s  = rsp_data_r;
    rsp_err_nxt_s   = rsp_err_r;
    pop_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_REQ;
          cyc_nxt_s   = 1'b1;
          we_nxt_s    = head_s[CMD_W-1];
          adr_nxt_s   = head_s[DATA_WIDTH +: ADDR_WIDTH];
          dat_nxt_s   = head_s[DATA_WIDTH-1:0];
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_i || err_i || timeout_s) begin
          state_nxt_s     = ST_RSP;
          cyc_nxt_s       = 1'b0;
          we_nxt_s        = 1'b0;
          adr_nxt_s       = '0;
          dat_nxt_s       = '0;
          rsp_valid_nxt_s = 1'b1;
          rsp_we_nxt_s    = we_r;
          // A real slave answer (even on the timeout edge) beats the timeout;
          // err_i wins over ack_i but read data is still captured.
          if (ack_i || err_i) begin
            rsp_data_nxt_s = we_r ? dat_r : dat_i;
            rsp_err_nxt_s  = err_i;
          end else begin
            rsp_data_nxt_s = '0;
            rsp_err_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_RSP;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        cyc_nxt_s       = 1'b0;
        we_nxt_s        = 1'b0;
        adr_nxt_s       = '0;
        dat_nxt_s       = '0;
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset drops the bus at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= '0;
      dat_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cyc_r       <= cyc_nxt_s;
      we_r        <= we_nxt_s;
      adr_r       <= adr_nxt_s;
      dat_r       <= dat_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_we_r    <= rsp_we_nxt_s;
      rsp_data_r  <= rsp_data_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
    end
  end

  assign cmd_ready_o = !full_s;
  assign busy_o      = !empty_s || (state_r != ST_IDLE);
  assign cyc_o       = cyc_r;
  assign stb_o       = cyc_r;
  assign we_o        = we_r;
  assign adr_o       = adr_r;
  assign dat_o       = dat_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_we_o    = rsp_we_r;
  assign rsp_data_o  = rsp_data_r;
  assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios followed by a
// randomized phase compared against a queue-based transaction model.
module tb_wb_cmd_master;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [DW-1:0] cmd_data_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic          rsp_we_o;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_err_o;
  logic          busy_o;
  logic          cyc_o, stb_o, we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i = '0;
  logic          ack_i = 1'b0;
  logic          err_i = 1'b0;

  wb_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  int   checks = 0;
  int   failures = 0;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one command starting at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_data_i = d;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check_val("push_ready", cmd_ready_o, 1'b1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_cyc(input string tag);
    int n = 0;
    while (!cyc_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check_val(tag, cyc_o, 1'b1);
  endtask

  // Act as the slave for one cycle: check the request, answer after 'delay' extra clocks.
  task automatic bus_reply(input cmd_t c, input logic ack, input logic err,
                           input logic [DW-1:0] d, input int delay, input string tag);
    wait_cyc({tag, "_cyc"});
    check_val({tag, "_stb"}, stb_o, 1'b1);
    check_val({tag, "_we"}, we_o, c.we);
    check_val({tag, "_adr"}, adr_o, c.addr);
    if (c.we) check_val({tag, "_dat"}, dat_o, c.data);
    repeat (delay) @(negedge clk_i);
    ack_i = ack; err_i = err; dat_i = d;
    @(negedge clk_i);
    ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    check_val({tag, "_cyc_drop"}, cyc_o, 1'b0);
    check_val({tag, "_idle_bus"}, {adr_o, dat_o, we_o, stb_o}, 64'd0);
  endtask

  task automatic take_rsp(input logic we, input logic [DW-1:0] d, input logic err, input string tag);
    int n = 0;
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check_val({tag, "_valid"}, rsp_valid_o, 1'b1);
    check_val({tag, "_we"}, rsp_we_o, we);
    check_val({tag, "_data"}, rsp_data_o, d);
    check_val({tag, "_err"}, rsp_err_o, err);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check_val({tag, "_released"}, rsp_valid_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    rsp_t e;
    int   n, r, wait_left;
    logic prev_cyc, acked, feed;
    cmd_t cur;

    // Reset state
    repeat (3) @(negedge clk_i);
    check_val("rst_cyc", {cyc_o, stb_o, we_o}, 64'd0);
    check_val("rst_bus", {adr_o, dat_o}, 64'd0);
    check_val("rst_rsp", {rsp_valid_o, rsp_we_o, rsp_data_o, rsp_err_o}, 64'd0);
    check_val("rst_busy", busy_o, 1'b0);
    check_val("rst_ready", cmd_ready_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Write 0x4 <= 0xBEEF, ack on the second cycle of cyc_o
    c = '{we: 1'b1, addr: 32'h4, data: 16'hBEEF};
    push(c.we, c.addr, c.data);
    check_val("wr_latency_lo", cyc_o, 1'b0);
    check_val("wr_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check_val("wr_latency_hi", cyc_o, 1'b1);
    bus_reply(c, 1'b1, 1'b0, 16'h0, 1, "wr");
    take_rsp(1'b1, 16'hBEEF, 1'b0, "wr_rsp");

    // Read 0x8 returning 0x1234
    c = '{we: 1'b0, addr: 32'h8, data: 16'h0};
    push(c.we, c.addr, c.data);
    bus_reply(c, 1'b1, 1'b0, 16'h1234, 0, "rd");
    take_rsp(1'b0, 16'h1234, 1'b0, "rd_rsp");
    check_val("rd_busy_done", busy_o, 1'b0);

    // Five commands with responses blocked: one executing plus four buffered fills the FIFO
    for (int i = 0; i < 5; i++) push(1'(i), 32'h100 + 32'(4 * i), 16'hA000 + 16'(i));
    check_val("fill_ready_lo", cmd_ready_o, 1'b0);
    c = '{we: 1'b0, addr: 32'h100, data: 16'hA000};
    bus_reply(c, 1'b1, 1'b0, 16'hC000, 0, "fill0");
    check_val("fill_hold_ready_lo", cmd_ready_o, 1'b0);
    for (int i = 0; i < 5; i++) begin
      take_rsp(1'(i), (i % 2 == 1) ? 16'hA000 + 16'(i) : 16'hC000 + 16'(i), 1'b0, "fill_rsp");
      if (i < 4) begin
        c = '{we: 1'(i + 1), addr: 32'h100 + 32'(4 * (i + 1)), data: 16'hA000 + 16'(i + 1)};
        bus_reply(c, 1'b1, 1'b0, 16'hC000 + 16'(i + 1), i % 3, "fill");
      end
    end
    check_val("fill_ready_back", cmd_ready_o, 1'b1);

    // ack and err together on a read: error wins, data captured, next command still runs
    push(1'b0, 32'h10, 16'h0);
    push(1'b1, 32'h14, 16'h7777);
    c = '{we: 1'b0, addr: 32'h10, data: 16'h0};
    bus_reply(c, 1'b1, 1'b1, 16'h5A5A, 0, "ackerr");
    take_rsp(1'b0, 16'h5A5A, 1'b1, "ackerr_rsp");
    c = '{we: 1'b1, addr: 32'h14, data: 16'h7777};
    bus_reply(c, 1'b1, 1'b0, 16'h0, 1, "after_err");
    take_rsp(1'b1, 16'h7777, 1'b0, "after_err_rsp");

    // Silent slave
    push(1'b0, 32'h20, 16'h0);
    wait_cyc("silent_cyc");
    n = 1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    while (cyc_o && n < 300) begin
      @(negedge clk_i);
      if (cyc_o) n++;
    end
    check_val("timeout_len", n, TO);
    take_rsp(1'b0, 16'h0, 1'b1, "timeout_rsp");
`else
    while (cyc_o && n < 120) begin
      @(negedge clk_i);
      if (cyc_o) n++;
    end
    check_val("no_timeout_len", n, 120);
    ack_i = 1'b1; dat_i = 16'h4321;
    @(negedge clk_i);
    ack_i = 1'b0; dat_i = '0;
    take_rsp(1'b0, 16'h4321, 1'b0, "late_ack_rsp");
`endif

    // Reset in the middle of a cycle with two commands still queued
    push(1'b0, 32'h30, 16'h0);
    push(1'b0, 32'h34, 16'h0);
    push(1'b0, 32'h38, 16'h0);
    check_val("mid_cyc_hi", cyc_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    check_val("mid_rst_cyc", {cyc_o, stb_o}, 64'd0);
    check_val("mid_rst_busy", busy_o, 1'b0);
    check_val("mid_rst_rsp", rsp_valid_o, 1'b0);
    check_val("mid_rst_ready", cmd_ready_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (cyc_o || busy_o) n++;
    end
    check_val("post_rst_quiet", n, 0);
    c = '{we: 1'b1, addr: 32'h40, data: 16'h0F0F};
    push(c.we, c.addr, c.data);
    bus_reply(c, 1'b1, 1'b0, 16'h0, 0, "post_rst");
    take_rsp(1'b1, 16'h0F0F, 1'b0, "post_rst_rsp");
    check_val("post_rst_idle", busy_o, 1'b0);

    // Randomized traffic against the transaction model
    wait_left = 0; prev_cyc = 1'b0; acked = 1'b0;
    cur = '{we: 1'b0, addr: '0, data: '0};
    for (int t = 0; t < 900; t++) begin
      @(negedge clk_i);
      feed = (t < 600);
      if (!feed && cmd_q.size() == 0 && rsp_q.size() == 0 && !busy_o && !rsp_valid_o) break;
      if (acked) check_val("rnd_cyc_drop", cyc_o, 1'b0);
      acked = 1'b0;
      if (cyc_o && !prev_cyc) begin
        if (cmd_q.size() == 0) begin
          check_val("rnd_unexpected_cyc", cyc_o, 1'b0);
        end else begin
          cur = cmd_q.pop_front();
          check_val("rnd_we", we_o, cur.we);
          check_val("rnd_adr", adr_o, cur.addr);
          if (cur.we) check_val("rnd_dat", dat_o, cur.data);
          wait_left = $urandom_range(0, 3);
        end
      end
      if (!cyc_o) check_val("rnd_idle_bus", {adr_o, dat_o, we_o}, 64'd0);
      prev_cyc = cyc_o;
      dat_i = DW'($urandom);
      if (cyc_o) begin
        if (wait_left == 0) begin
          r = $urandom_range(0, 3);
          ack_i = (r != 0);
          err_i = (r <= 1);
          e.we = cur.we;
          e.data = cur.we ? cur.data : dat_i;
          e.err = err_i;
          rsp_q.push_back(e);
          acked = 1'b1;
        end else begin
          ack_i = 1'b0; err_i = 1'b0;
          wait_left--;
        end
      end else begin
        // Stray handshakes outside a cycle must be ignored
        ack_i = 1'($urandom); err_i = 1'($urandom);
      end
      rsp_ready_i = 1'($urandom);
      if (rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) begin
          check_val("rnd_unexpected_rsp", rsp_valid_o, 1'b0);
        end else begin
          e = rsp_q.pop_front();
          check_val("rnd_rsp_we", rsp_we_o, e.we);
          check_val("rnd_rsp_data", rsp_data_o, e.data);
          check_val("rnd_rsp_err", rsp_err_o, e.err);
        end
      end
      cmd_valid_i = feed ? 1'($urandom) : 1'b0;
      cmd_we_i = 1'($urandom);
      cmd_addr_i = AW'($urandom);
      cmd_data_i = DW'($urandom);
      if (cmd_valid_i && cmd_ready_o) begin
        c.we = cmd_we_i; c.addr = cmd_addr_i; c.data = cmd_data_i;
        cmd_q.push_back(c);
      end
    end
    cmd_valid_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; rsp_ready_i = 1'b0;
    check_val("rnd_cmds_left", cmd_q.size(), 0);
    check_val("rnd_rsps_left", rsp_q.size(), 0);
    check_val("rnd_final_busy", busy_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
